// File: rtl/debug_glyph_scheduler.sv
// Debug glyph scheduler: snapshots the debug values on each frame start and
// re-renders the entries that changed since their last render. Each glyph row
// is fetched from the font ROM over a req/ack handshake and written to the
// glyph buffer.
//
// Handshake: font_req rises in REQ and stays high, with font_code/font_row
// held stable, until a cycle in which font_ack is high. That cycle completes
// the transfer and font_bits is captured. font_ack is ignored while font_req
// is low.
module debug_glyph_scheduler #(
  parameter int SEQ_NUM    = 34,
  parameter int SEQ_DIGITS = 4,
  parameter int FONT_WIDTH = 8,
  parameter int SEQ_IDX_W  = 6
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic                           frame_start,
  input  logic [SEQ_NUM*4*SEQ_DIGITS-1:0] values,
  output logic                           font_req,
  output logic [3:0]                     font_code,
  output logic [2:0]                     font_row,
  input  logic                           font_ack,
  input  logic [FONT_WIDTH-1:0]          font_bits,
  output logic                           wr_en,
  output logic [SEQ_IDX_W-1:0]           wr_seq,
  output logic [2:0]                     wr_row,
  output logic [1:0]                     wr_digit,
  output logic [FONT_WIDTH-1:0]          wr_bits,
  output logic                           busy,
  output logic                           done,
  output logic                           overrun
);

  localparam int VW = 4 * SEQ_DIGITS;
  localparam logic [1:0]           LAST_DIGIT = 2'(SEQ_DIGITS - 1);
  localparam logic [2:0]           LAST_ROW   = 3'(FONT_WIDTH - 1);
  localparam logic [SEQ_IDX_W-1:0] LAST_IDX   = SEQ_IDX_W'(SEQ_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_REQ,
    S_WR,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [SEQ_IDX_W-1:0]   idx_q, idx_d;
  logic [2:0]             row_q, row_d;
  logic [1:0]             digit_q, digit_d;
  logic                   pending_q, pending_d;
  logic                   force_all_q, force_all_d;
  logic [FONT_WIDTH-1:0]  wr_bits_q, wr_bits_d;
  logic [VW-1:0]          snap_q [SEQ_NUM];
  logic [VW-1:0]          snap_d [SEQ_NUM];
  logic [VW-1:0]          shadow_q [SEQ_NUM];
  logic [VW-1:0]          shadow_d [SEQ_NUM];

  logic [VW-1:0]          cur_val;
  logic [3:0]             code_shift;
  logic [3:0]             cur_code;

  // State and datapath registers; reset aborts any pass and forces a full redraw.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      row_q       <= '0;
      digit_q     <= '0;
      pending_q   <= 1'b0;
      force_all_q <= 1'b1;
      wr_bits_q   <= '0;
      for (int i = 0; i < SEQ_NUM; i++) begin
        snap_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      row_q       <= row_d;
      digit_q     <= digit_d;
      pending_q   <= pending_d;
      force_all_q <= force_all_d;
      wr_bits_q   <= wr_bits_d;
      snap_q      <= snap_d;
      shadow_q    <= shadow_d;
    end
  end

  // Next-state logic, pass sequencing and Moore outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    row_d       = row_q;
    digit_d     = digit_q;
    pending_d   = pending_q;
    force_all_d = force_all_q;
    wr_bits_d   = wr_bits_q;
    snap_d      = snap_q;
    shadow_d    = shadow_q;
    font_req    = 1'b0;
    wr_en       = 1'b0;
    done        = 1'b0;
    overrun     = 1'b0;

    busy       = (state_q != S_IDLE);
    cur_val    = snap_q[idx_q];
    // Digit 0 is the most significant nibble.
    code_shift = {LAST_DIGIT - digit_q, 2'b00};
    cur_code   = cur_val[code_shift +: 4];

    // A frame start that arrives mid-pass is remembered once; a second is lost.
    if (busy && frame_start) begin
      if (pending_q) overrun = 1'b1;
      else           pending_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (frame_start || pending_q) begin
          for (int i = 0; i < SEQ_NUM; i++) snap_d[i] = values[i*VW +: VW];
          pending_d = 1'b0;
          idx_d     = '0;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (force_all_q || (snap_q[idx_q] != shadow_q[idx_q])) begin
          row_d   = '0;
          digit_d = '0;
          state_d = S_REQ;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_REQ: begin
        font_req = 1'b1;
        if (font_ack) begin
          wr_bits_d = font_bits;
          state_d   = S_WR;
        end
      end
      S_WR: begin
        wr_en = 1'b1;
        if (digit_q == LAST_DIGIT) begin
          digit_d = '0;
          if (row_q == LAST_ROW) begin
            shadow_d[idx_q] = snap_q[idx_q];
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_SCAN;
            end
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_REQ;
          end
        end else begin
          digit_d = digit_q + 1'b1;
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        force_all_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign font_code = font_req ? cur_code : 4'h0;
  assign font_row  = row_q;
  assign wr_seq    = idx_q;
  assign wr_row    = row_q;
  assign wr_digit  = digit_q;
  assign wr_bits   = wr_bits_q;

endmodule

// File: tb/tb_debug_glyph_scheduler.sv
// Testbench for debug_glyph_scheduler: a font ROM responder with randomized
// ack latency, a write scoreboard fed by a pass-level reference model, and one
// task per scenario.
module tb_debug_glyph_scheduler;

  localparam int SEQ_NUM    = 34;
  localparam int SEQ_DIGITS = 4;
  localparam int FONT_WIDTH = 8;
  localparam int SEQ_IDX_W  = 6;
  localparam int VW         = 4 * SEQ_DIGITS;
  localparam int W          = SEQ_IDX_W + 3 + 2 + FONT_WIDTH;

  logic                          sys_clk = 1'b0;
  logic                          sys_rst_n = 1'b0;
  logic                          frame_start = 1'b0;
  logic [SEQ_NUM*VW-1:0]         values = '0;
  logic                          font_req;
  logic [3:0]                    font_code;
  logic [2:0]                    font_row;
  logic                          font_ack = 1'b0;
  logic [FONT_WIDTH-1:0]         font_bits = '0;
  logic                          wr_en;
  logic [SEQ_IDX_W-1:0]          wr_seq;
  logic [2:0]                    wr_row;
  logic [1:0]                    wr_digit;
  logic [FONT_WIDTH-1:0]         wr_bits;
  logic                          busy;
  logic                          done;
  logic                          overrun;

  debug_glyph_scheduler #(
    .SEQ_NUM(SEQ_NUM), .SEQ_DIGITS(SEQ_DIGITS),
    .FONT_WIDTH(FONT_WIDTH), .SEQ_IDX_W(SEQ_IDX_W)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .frame_start(frame_start),
    .values(values), .font_req(font_req), .font_code(font_code),
    .font_row(font_row), .font_ack(font_ack), .font_bits(font_bits),
    .wr_en(wr_en), .wr_seq(wr_seq), .wr_row(wr_row), .wr_digit(wr_digit),
    .wr_bits(wr_bits), .busy(busy), .done(done), .overrun(overrun)
  );

  // Clock / reset block
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  int wr_cnt  = 0;
  int ovr_cnt = 0;
  int ack_min = 0;
  int ack_max = 0;

  logic [VW-1:0] tb_vals [SEQ_NUM];
  logic [VW-1:0] mdl_shadow [SEQ_NUM];
  bit            mdl_force;

  // Synthetic font: every (code,row) pair gets a distinct pattern.
  function automatic logic [7:0] font(input logic [3:0] c, input logic [2:0] r);
    return {c, r, ^{c, r}};
  endfunction

  // Font ROM responder: random latency per request, garbage on font_bits
  // except in the ack cycle; also checks request fields stay stable.
  initial begin : rom_responder
    bit         in_req;
    int         wait_cnt;
    logic [3:0] held_code;
    logic [2:0] held_row;
    in_req = 0;
    wait_cnt = 0;
    held_code = '0;
    held_row = '0;
    forever begin
      @(negedge sys_clk);
      font_bits = 8'($urandom);
      if (font_req) begin
        if (!in_req) begin
          in_req    = 1;
          wait_cnt  = $urandom_range(ack_max, ack_min);
          held_code = font_code;
          held_row  = font_row;
        end else begin
          n_checks++;
          if ({font_code, font_row} !== {held_code, held_row}) begin
            n_errors++;
            $display("FAIL req_stable: code=%h row=%0d, required code=%h row=%0d",
                     font_code, font_row, held_code, held_row);
          end
        end
        if (wait_cnt == 0) begin
          font_ack  = 1'b1;
          font_bits = font(font_code, font_row);
          in_req    = 0;
        end else begin
          wait_cnt--;
          font_ack = 1'b0;
        end
      end else begin
        font_ack = 1'b0;
        in_req   = 0;
      end
    end
  end

  // Scoreboard: every write is matched in order against the expected queue.
  logic [W-1:0] mon_got, mon_exp;
  always @(negedge sys_clk) begin
    if (overrun) ovr_cnt++;
    if (wr_en) begin
      wr_cnt++;
      n_checks++;
      mon_got = {wr_seq, wr_row, wr_digit, wr_bits};
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got seq=%0d row=%0d digit=%0d bits=%h, required no write",
                 wr_seq, wr_row, wr_digit, wr_bits);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_errors++;
          $display("FAIL write: got seq=%0d row=%0d digit=%0d bits=%h, required seq=%0d row=%0d digit=%0d bits=%h",
                   mon_got[W-1 -: SEQ_IDX_W], mon_got[12:10], mon_got[9:8], mon_got[7:0],
                   mon_exp[W-1 -: SEQ_IDX_W], mon_exp[12:10], mon_exp[9:8], mon_exp[7:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    mdl_force = 1;
    for (int i = 0; i < SEQ_NUM; i++) mdl_shadow[i] = '0;
    exp_q.delete();
  endtask

  // Expected writes for a pass that snapshots the current tb_vals.
  task automatic model_expect(output int dirty);
    logic [3:0] code;
    dirty = 0;
    for (int i = 0; i < SEQ_NUM; i++) begin
      if (mdl_force || tb_vals[i] != mdl_shadow[i]) begin
        dirty++;
        for (int r = 0; r < FONT_WIDTH; r++)
          for (int d = 0; d < SEQ_DIGITS; d++) begin
            code = 4'((tb_vals[i] >> (4 * (SEQ_DIGITS - 1 - d))) & 16'hF);
            exp_q.push_back({SEQ_IDX_W'(i), 3'(r), 2'(d), font(code, 3'(r))});
          end
        mdl_shadow[i] = tb_vals[i];
      end
    end
    mdl_force = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_values();
    for (int i = 0; i < SEQ_NUM; i++) values[i*VW +: VW] = tb_vals[i];
  endtask

  task automatic pulse_frame();
    @(posedge sys_clk); #1 frame_start = 1'b1;
    @(posedge sys_clk); #1 frame_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int nbusy);
    int t;
    t = 0;
    nbusy = 0;
    @(negedge sys_clk);
    while (!done && t < limit) begin
      if (busy) nbusy++;
      t++;
      @(negedge sys_clk);
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL done_timeout: no done within %0d cycles", limit);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if ({font_req, font_code, font_row, wr_en, wr_seq, wr_row, wr_digit, wr_bits,
         busy, done, overrun} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: req=%b code=%h wr_en=%b bits=%h busy=%b done=%b, required all 0",
               font_req, font_code, wr_en, wr_bits, busy, done);
    end
    @(posedge sys_clk); #1 sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check_int("idle_after_reset_busy", int'(busy), 0);
    model_reset();
  endtask

  task automatic test_full_render();
    int dirty, nb;
    ack_min = 0; ack_max = 0;
    for (int i = 0; i < SEQ_NUM; i++) tb_vals[i] = '0;
    apply_values();
    model_expect(dirty);
    wr_cnt = 0;
    pulse_frame();
    wait_done(5000, nb);
    check_int("full_busy_cycles", nb, SEQ_NUM + SEQ_NUM * 64);
    check_int("full_writes", wr_cnt, SEQ_NUM * 32);
    check_int("full_queue_left", exp_q.size(), 0);
    @(negedge sys_clk);
    check_int("done_one_cycle", int'(done), 0);
  endtask

  task automatic test_unchanged();
    int dirty, nb;
    model_expect(dirty);
    wr_cnt = 0;
    pulse_frame();
    wait_done(500, nb);
    check_int("clean_busy_cycles", nb, SEQ_NUM);
    check_int("clean_writes", wr_cnt, 0);
  endtask

  task automatic test_single_entry();
    int dirty, nb;
    tb_vals[5] = 16'hA3F0;
    apply_values();
    model_expect(dirty);
    wr_cnt = 0;
    pulse_frame();
    wait_done(1000, nb);
    check_int("single_busy_cycles", nb, SEQ_NUM + 64);
    check_int("single_writes", wr_cnt, 32);
    check_int("single_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_ack_delay();
    int dirty, nb, t, hi;
    ack_min = 3; ack_max = 3;
    tb_vals[7] = mdl_shadow[7] ^ 16'($urandom_range(65535, 1));
    apply_values();
    model_expect(dirty);
    wr_cnt = 0;
    pulse_frame();
    t = 0;
    while (!font_req && t < 100) begin
      t++;
      @(negedge sys_clk);
    end
    hi = 0;
    while (font_req && hi < 20) begin
      hi++;
      @(negedge sys_clk);
    end
    check_int("delayed_req_cycles", hi, 4);
    wait_done(2000, nb);
    check_int("delayed_writes", wr_cnt, 32);
    check_int("delayed_queue_left", exp_q.size(), 0);
    ack_min = 0; ack_max = 0;
  endtask

  task automatic test_random_passes();
    int dirty, nb, k, e;
    for (int p = 0; p < 6; p++) begin
      ack_min = 0;
      ack_max = $urandom_range(2, 0);
      k = $urandom_range(4, 0);
      for (int j = 0; j < k; j++) begin
        e = $urandom_range(SEQ_NUM - 1, 0);
        tb_vals[e] = 16'($urandom);
      end
      apply_values();
      model_expect(dirty);
      wr_cnt = 0;
      pulse_frame();
      // Values moving after the snapshot must not leak into this pass.
      e = $urandom_range(SEQ_NUM - 1, 0);
      tb_vals[e] = tb_vals[e] ^ 16'h5A5A;
      apply_values();
      wait_done(20000, nb);
      check_int("rand_writes", wr_cnt, 32 * dirty);
      check_int("rand_queue_left", exp_q.size(), 0);
    end
    ack_min = 0; ack_max = 0;
  endtask

  task automatic test_back_to_back();
    int da, db, nb, ovr0;
    tb_vals[2]  = tb_vals[2] ^ 16'h1111;
    tb_vals[20] = tb_vals[20] ^ 16'h0F0F;
    apply_values();
    model_expect(da);
    wr_cnt = 0;
    ovr0 = ovr_cnt;
    pulse_frame();
    repeat (5) @(negedge sys_clk);
    tb_vals[0]  = tb_vals[0] ^ 16'h8001;
    tb_vals[17] = tb_vals[17] ^ 16'h00F0;
    tb_vals[33] = tb_vals[33] ^ 16'hFFFF;
    apply_values();
    pulse_frame();
    repeat (2) @(negedge sys_clk);
    check_int("first_extra_no_overrun", ovr_cnt - ovr0, 0);
    pulse_frame();
    @(negedge sys_clk);
    check_int("second_extra_overrun", ovr_cnt - ovr0, 1);
    wait_done(5000, nb);
    check_int("pass_a_queue_left", exp_q.size(), 0);
    model_expect(db);
    @(negedge sys_clk);
    check_int("gap_after_done_busy", int'(busy), 0);
    wait_done(5000, nb);
    check_int("pass_b_busy_cycles", nb, SEQ_NUM + 64 * db);
    check_int("b2b_writes", wr_cnt, 32 * (da + db));
    check_int("pass_b_queue_left", exp_q.size(), 0);
    check_int("total_overruns", ovr_cnt - ovr0, 1);
  endtask

  task automatic test_reset_mid_pass();
    int dirty, nb, t;
    ack_min = 3; ack_max = 3;
    tb_vals[9] = tb_vals[9] ^ 16'h2222;
    apply_values();
    model_expect(dirty);
    pulse_frame();
    t = 0;
    while (!font_req && t < 100) begin
      t++;
      @(negedge sys_clk);
    end
    check_int("reached_req", int'(font_req), 1);
    @(posedge sys_clk); #1 sys_rst_n = 1'b0;
    model_reset();
    @(posedge sys_clk); #1 sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check_int("reset_req_low", int'(font_req), 0);
    check_int("reset_busy_low", int'(busy), 0);
    repeat (5) @(negedge sys_clk);
    ack_min = 0; ack_max = 0;
    model_expect(dirty);
    wr_cnt = 0;
    pulse_frame();
    wait_done(5000, nb);
    check_int("rerender_writes", wr_cnt, SEQ_NUM * 32);
    check_int("rerender_busy_cycles", nb, SEQ_NUM + SEQ_NUM * 64);
    check_int("rerender_queue_left", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < SEQ_NUM; i++) tb_vals[i] = '0;
    model_reset();
    test_reset();
    test_full_render();
    test_unchanged();
    test_single_entry();
    test_ack_delay();
    test_random_passes();
    test_back_to_back();
    test_reset_mid_pass();
    repeat (5) @(negedge sys_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
